// File: rtl/mmio_uart_tx_pkg.sv
// Register map, bit positions and FSM encodings shared by the UART TX slice.
// Optional parity stage is compiled in with UART_TX_PARITY_EN.
package mmio_uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 8;

  localparam int CT_EN  = 0;
  localparam int CT_IRQ = 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous transmit FIFO; pointers wrap naturally (power-of-two depth).
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/CTRL window plus FIFO.
// Define UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0020_0000,
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic [29:0] ADDR,
  input  logic [31:0] DATAI,
  input  logic [3:0]  WSTB,
  output logic [31:0] DATAO,
  output logic        TXD,
  output logic        IRQ
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] RELOAD = BW'(CLK_DIV - 1);

  logic          sel;
  logic [1:0]    rsel;
  logic          wr0;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [7:0]    head;
  logic [1:0]    ctrl;
  logic          ovf;
  logic [2:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          busy;
  logic          can_start;
  logic          baud_done;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{ADDR[17:2], DATAI[31:8], WSTB[3:1]};

  assign sel  = CE && (ADDR[29:18] == BASE[31:20]);
  assign rsel = ADDR[1:0];
  assign wr0  = sel && WSTB[0];
  assign push = wr0 && (rsel == REG_TXDATA);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .din   (DATAI[7:0]),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl <= '0;
      ovf  <= 1'b0;
    end else begin
      if (wr0 && rsel == REG_CTRL) ctrl <= DATAI[1:0];
      // A dropped push wins over a same-cycle clear so the event is not lost
      if (push && full)
        ovf <= 1'b1;
      else if (wr0 && rsel == REG_STATUS && DATAI[ST_OVF])
        ovf <= 1'b0;
    end
  end

  assign busy      = (state != S_IDLE);
  assign can_start = ctrl[CT_EN] && !empty;
  assign baud_done = (baud == '0);
  assign pop       = can_start &&
                     ((state == S_IDLE) || (state == S_STOP && baud_done));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      baud   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (can_start) begin
            state <= S_START;
            baud  <= RELOAD;
            shreg <= head;
          end
        end
        S_START: begin
          if (baud_done) begin
            state  <= S_DATA;
            baud   <= RELOAD;
            bitcnt <= '0;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud <= RELOAD;
            if (bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state  <= S_PARITY;
`else
              state  <= S_STOP;
`endif
              bitcnt <= '0;
            end else begin
              bitcnt <= bitcnt + 3'd1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            state <= S_STOP;
            baud  <= RELOAD;
          end else begin
            baud <= baud - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud_done) begin
            if (can_start) begin
              state <= S_START;
              baud  <= RELOAD;
              shreg <= head;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    TXD = 1'b1;
    unique case (state)
      S_START:  TXD = 1'b0;
      S_DATA:   TXD = shreg[bitcnt];
`ifdef UART_TX_PARITY_EN
      S_PARITY: TXD = ^shreg;
`endif
      default:  TXD = 1'b1;
    endcase
  end

  assign IRQ = ctrl[CT_IRQ] && empty && !busy;

  always_comb begin
    status           = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY]  = busy;
    status[ST_OVF]   = ovf;
    status[ST_CNT +: 5] = 5'(count);
  end

  always_comb begin
    DATAO = '0;
    if (sel) begin
      unique case (rsel)
        REG_STATUS: DATAO = status;
        REG_CTRL:   DATAO = {30'b0, ctrl};
        default:    DATAO = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx against a queue/waveform reference model.
// Frame expectations follow UART_TX_PARITY_EN when it is defined.
module tb_mmio_uart_tx;

  localparam int          DIV   = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0020_0000;
  localparam logic [31:0] OTHER = 32'h0030_0000;

  logic        CLK;
  logic        RST;
  logic        CE;
  logic [29:0] ADDR;
  logic [31:0] DATAI;
  logic [3:0]  WSTB;
  logic [31:0] DATAO;
  logic        TXD;
  logic        IRQ;

  mmio_uart_tx #(
    .BASE(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .ADDR(ADDR),
    .DATAI(DATAI), .WSTB(WSTB), .DATAO(DATAO),
    .TXD(TXD), .IRQ(IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] mq[$];
  bit         movf;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] wa(input logic [31:0] base,
                                     input logic [3:0] off);
    logic [31:0] a;
    a = base + {28'b0, off};
    return a[31:2];
  endfunction

  function automatic logic [31:0] st(input int n, input bit ovf,
                                     input bit busy);
    logic [31:0] s;
    s       = '0;
    s[12:8] = 5'(n);
    s[3]    = ovf;
    s[2]    = busy;
    s[1]    = (n == 0);
    s[0]    = (n == DEPTH);
    return s;
  endfunction

  task automatic bus_wr(input logic [31:0] base, input logic [3:0] off,
                        input logic [31:0] d);
    @(negedge CLK);
    CE    = 1'b1;
    ADDR  = wa(base, off);
    DATAI = d;
    WSTB  = 4'b0001;
    @(posedge CLK);
    #1;
    CE    = 1'b0;
    WSTB  = 4'b0000;
  endtask

  task automatic bus_rd(input logic [31:0] base, input logic [3:0] off,
                        output logic [31:0] d);
    @(negedge CLK);
    CE   = 1'b1;
    ADDR = wa(base, off);
    WSTB = 4'b0000;
    #1;
    d  = DATAO;
    CE = 1'b0;
  endtask

  function automatic void model_push(input logic [7:0] b);
    if (mq.size() == DEPTH) movf = 1'b1;
    else mq.push_back(b);
  endfunction

  // Caller has already passed the edge that pops the first byte.
  task automatic check_stream(input int nframes, input bit irq_en,
                              input int idle);
    logic       e[$];
    logic [7:0] b;
    int         nb;
    for (int f = 0; f < nframes; f++) begin
      b = mq.pop_front();
      repeat (DIV) e.push_back(1'b0);
      for (int k = 0; k < 8; k++) repeat (DIV) e.push_back(b[k]);
`ifdef UART_TX_PARITY_EN
      repeat (DIV) e.push_back(^b);
`endif
      repeat (DIV) e.push_back(1'b1);
    end
    nb = e.size();
    repeat (idle) e.push_back(1'b1);
    for (int i = 0; i < e.size(); i++) begin
      @(negedge CLK);
      chk($sformatf("txd[%0d]", i), {31'b0, TXD}, {31'b0, e[i]});
      chk($sformatf("irq[%0d]", i), {31'b0, IRQ},
          {31'b0, (i >= nb) ? irq_en : 1'b0});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  logic [31:0] rd;
  logic [7:0]  b;
  int          n;

  initial begin
    RST   = 1'b1;
    CE    = 1'b0;
    ADDR  = '0;
    DATAI = '0;
    WSTB  = '0;
    movf  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst txd", {31'b0, TXD}, 32'd1);
    chk("rst irq", {31'b0, IRQ}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    bus_rd(BASE, 4'h4, rd);  chk("reset status", rd, 32'h0000_0002);
    chk("idle txd", {31'b0, TXD}, 32'd1);
    chk("idle irq", {31'b0, IRQ}, 32'd0);
    bus_rd(BASE, 4'h0, rd);  chk("txdata rd", rd, 32'd0);
    bus_rd(BASE, 4'h8, rd);  chk("ctrl rd", rd, 32'd0);
    bus_rd(BASE, 4'hC, rd);  chk("rsvd rd", rd, 32'd0);
    bus_rd(OTHER, 4'h4, rd); chk("unsel rd", rd, 32'd0);

    bus_wr(OTHER, 4'h0, 32'h0000_00A5);
    bus_wr(BASE, 4'hC, 32'hFFFF_FFFF);
    bus_rd(BASE, 4'h4, rd);  chk("unsel wr", rd, st(0, 0, 0));

    n = $urandom_range(17, 20);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      bus_wr(BASE, 4'h0, {24'($urandom), b});
      model_push(b);
      bus_rd(BASE, 4'h4, rd);
      chk($sformatf("fill%0d", i), rd, st(mq.size(), movf, 0));
    end

    bus_wr(BASE, 4'h4, 32'hFFFF_FFF7);
    bus_rd(BASE, 4'h4, rd);  chk("ovf keep", rd, st(DEPTH, 1, 0));
    bus_wr(BASE, 4'h4, 32'h0000_0008);
    movf = 1'b0;
    bus_rd(BASE, 4'h4, rd);  chk("ovf clr", rd, st(DEPTH, 0, 0));

    bus_wr(BASE, 4'h8, 32'h0000_0003);
    bus_wr(BASE, 4'h0, 32'h0000_00C3);
    model_push(8'hC3);
    check_stream(DEPTH, 1'b1, 10);
    bus_rd(BASE, 4'h4, rd);  chk("drain status", rd, st(0, movf, 0));
    bus_rd(BASE, 4'h8, rd);  chk("ctrl rb", rd, 32'd3);
    chk("drain irq", {31'b0, IRQ}, 32'd1);
    bus_wr(BASE, 4'h4, 32'h0000_0008);
    movf = 1'b0;
    bus_wr(BASE, 4'h8, 32'h0000_0000);
    bus_rd(BASE, 4'h4, rd);  chk("status2", rd, 32'h0000_0002);
    chk("irq off", {31'b0, IRQ}, 32'd0);

    model_push(8'($urandom));
    model_push(8'h00);
    model_push(8'($urandom));
    for (int i = 0; i < 3; i++) bus_wr(BASE, 4'h0, {24'b0, mq[i]});
    bus_rd(BASE, 4'h4, rd);  chk("q3", rd, st(3, 0, 0));
    bus_wr(BASE, 4'h8, 32'h0000_0001);
    @(posedge CLK);
    fork
      check_stream(1, 1'b0, 30);
      begin
        repeat (6) @(posedge CLK);
        bus_wr(BASE, 4'h8, 32'h0000_0000);
      end
    join
    bus_rd(BASE, 4'h4, rd);  chk("disable", rd, st(mq.size(), 0, 0));

    bus_wr(BASE, 4'h8, 32'h0000_0001);
    repeat (16) @(posedge CLK);
    #2;
    chk("pre-rst txd", {31'b0, TXD}, 32'd0);
    RST = 1'b1;
    #1;
    chk("mid rst txd", {31'b0, TXD}, 32'd1);
    chk("mid rst irq", {31'b0, IRQ}, 32'd0);
    mq.delete();
    movf = 1'b0;
    bus_rd(BASE, 4'h4, rd);  chk("in rst st", rd, 32'h0000_0002);
    @(negedge CLK);
    RST = 1'b0;
    bus_rd(BASE, 4'h4, rd);  chk("post rst st", rd, 32'h0000_0002);
    bus_rd(BASE, 4'h8, rd);  chk("post rst ctrl", rd, 32'd0);
    repeat (DIV * 12) @(posedge CLK);
    #1;
    chk("post rst txd", {31'b0, TXD}, 32'd1);

    bus_wr(BASE, 4'h0, 32'h0000_0055);
    model_push(8'h55);
    bus_wr(BASE, 4'h8, 32'h0000_0001);
    @(posedge CLK);
    check_stream(1, 1'b0, 8);
    bus_rd(BASE, 4'h4, rd);  chk("0x55 done", rd, st(0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE, default 32'h0020_0000, 1 MB-aligned base address of the register window.
REQ-002 Parameter CLK_DIV, default 868, CLK cycles per serial bit (≥2).
REQ-003 Parameter FIFO_DEPTH, default 16, transmit FIFO entries (power of two, ≥2).
REQ-004 CLK  in  1  clock; reset RST, asynchronous, active-high.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 CE  in  1  data-bus access strobe from the core.
REQ-007 ADDR  in  30  word address [31:2] of the access.
REQ-008 DATAI  in  32  write data; byte lane n = DATAI[8n+7:8n].
REQ-009 WSTB  in  4  write byte strobes; 0000 = read access.
REQ-010 DATAO  out  32  read data.
REQ-011 TXD  out  1  serial output, idle high.
REQ-012 IRQ  out  1  level interrupt, active-high.

Function
REQ-013 Select SEL = CE && ADDR[31:20]==BASE[31:20]; register = ADDR[3:2]; no effect and DATAO=0 when SEL=0.
REQ-014 Reads combinational, same cycle, no side effects; writes take effect at the CLK edge where SEL && |WSTB.
REQ-015 Offset 0x0 TXDATA: write with WSTB[0] pushes DATAI[7:0]; reads 0.
REQ-016 Offset 0x4 STATUS (read): bit0 full, bit1 empty, bit2 busy (frame in progress), bit3 overflow (sticky), bits[12:8] count; other bits 0.
REQ-017 STATUS write with WSTB[0] and DATAI[3]=1 clears overflow; other bits ignored.
REQ-018 Offset 0x8 CTRL (R/W via WSTB[0]): bit0 TX enable, bit1 IRQ enable; offset 0xC reads 0, writes ignored.
REQ-019 Push while full: data dropped, overflow set, count unchanged; a pop in the same cycle does not rescue the push.
REQ-020 Push and pop in the same cycle while not full: both occur, count unchanged.
REQ-021 FSM IDLE->START->DATA->STOP->IDLE; in IDLE with enable=1 and FIFO non-empty, pop head and enter START next edge.
REQ-022 Each of START (TXD=0), each of 8 DATA bits (LSB first), STOP (TXD=1) lasts exactly CLK_DIV cycles via down-counter reloaded at CLK_DIV-1.
REQ-023 STOP->START back-to-back when enable=1 and FIFO non-empty: no idle gap beyond the stop bit.
REQ-024 Clearing enable mid-frame: current frame completes; no further pops.
REQ-025 busy = state != IDLE; IRQ = IRQ-enable && empty && !busy.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

Reset
REQ-027 RST asserted: TXD=1, IRQ=0, state IDLE, FIFO empty (count 0), overflow=0, CTRL=0, bit counter and baud counter 0; immediately, including mid-frame.
REQ-028 DATAO is combinational and after reset reads STATUS = 32'h0000_0002.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: PARITY state between DATA and STOP, CLK_DIV cycles, TXD = XOR of the 8 data bits (even parity); frame 11 bits.
REQ-030 Macro undefined: no PARITY state, frame 10 bits, no parity logic present.

Structure
REQ-031 Shared header src/Modules/uart_tx.vh holds register offsets, STATUS/CTRL bit positions and FSM state encodings.
REQ-032 Sub-module uart_tx_fifo: synchronous FIFO with push/pop/full/empty/count; all else in mmio_uart_tx.

Verification
REQ-033 Reset then read 0x4 -> DATAO=32'h0000_0002, TXD=1, IRQ=0.
REQ-034 CLK_DIV=4, CTRL=1, write 0x55 to 0x0 -> TXD low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, high 4 cycles, busy clears.
REQ-035 CTRL=0, FIFO_DEPTH=16, 17 writes -> count=16, full=1, overflow=1; write 0x8 to 0x4 -> overflow=0.
REQ-036 CTRL=1, two bytes queued -> second start bit begins exactly CLK_DIV cycles after first stop bit begins.
REQ-037 Assert RST mid-DATA -> TXD=1 same cycle, STATUS=32'h0000_0002 after release.
REQ-038 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 before stop; CTRL=3, drain FIFO -> IRQ rises after stop bit ends.
